id_ex_pipe_reg: RTL
===================

Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register for the 5-stage MIPS pipeline.
- Captures decoded operands, immediate, register addresses and control bits from the decode stage.
- Presents them to the execute stage one cycle later.
- Its ex_rt_data, ex_sign_ext_const and ex_alu_src outputs drive the execute-stage ALU operand-B mux directly.
- Supports stall (hold), flush (bubble) and valid tracking.

Parameters:
DATA_W, 32, datapath width
REG_ADDR_W, 5, register-file address width
ALUOP_W, 4, ALU operation code width

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
stall  input  1  hold current contents
flush  input  1  load bubble next edge
id_valid  input  1  decode stage holds a real instruction
id_pc_plus4  input  DATA_W  PC+4 of decode instruction
id_rs_data  input  DATA_W  register-file rs read data
id_rt_data  input  DATA_W  register-file rt read data
id_sign_ext_const  input  DATA_W  sign-extended immediate
id_rs  input  REG_ADDR_W  rs index
id_rt  input  REG_ADDR_W  rt index
id_rd  input  REG_ADDR_W  rd index
id_alu_op  input  ALUOP_W  ALU operation
id_alu_src  input  1  0 = rt data, 1 = immediate
id_reg_dst  input  1  0 = rt dest, 1 = rd dest
id_mem_read  input  1  load
id_mem_write  input  1  store
id_mem_to_reg  input  1  WB selects memory data
id_reg_write  input  1  instruction writes register file
wb_reg_write  input  1  WB-stage write enable (bypass only)
wb_rd  input  REG_ADDR_W  WB destination (bypass only)
wb_data  input  DATA_W  WB write data (bypass only)
ex_valid  output  1  EX holds a real instruction
ex_* (pc_plus4, rs_data, rt_data, sign_ext_const, rs, rt, rd, alu_op, alu_src, reg_dst, mem_read, mem_write, mem_to_reg, reg_write)  output  as id_*  registered copies

Behaviour:
- All outputs are flops. There is no combinational path from input to output.
- Latency: 1 cycle.
- Per-edge priority: reset > flush > stall > load.
- reset=1: every output goes to 0, including ex_valid.
- flush=1 (reset=0): every output goes to 0 (bubble). Flush wins over a simultaneous stall.
- stall=1 (no flush): all fields hold their value, except the rs/rt data under the optional bypass described below.
- Load with id_valid=1: all id_* fields are captured and ex_valid=1.
- Load with id_valid=0: loads a bubble, identical to flush.
- Bubble invariant: whenever ex_valid=0, ex_reg_write, ex_mem_read and ex_mem_write are 0.
- Reset asserted mid-stall clears the stage. Stall is ignored on that edge.
- Widths pass through unchanged. There is no arithmetic in this block.

Optional Feature:
IDEX_WB_BYPASS_EN
- Defined: on a load edge, if wb_reg_write=1, wb_rd!=0 and wb_rd==id_rs, then ex_rs_data captures wb_data. The same rule applies to rt.
- Defined, stall edge: the same comparison runs against the held ex_rs/ex_rt, and the held data updates to wb_data. This prevents stale operands after a WB write during a stall.
- Defined: register 0 is never bypassed.
- Not defined: the wb_* ports exist but are ignored. Data is captured straight from id_*, and held data never changes during stall.

Decomposition:
- Package idex_pkg holds:
  - DATA_W, REG_ADDR_W and ALUOP_W constants.
  - ALU op encodings.
  - alu_src / reg_dst select encodings.
  - A packed control-bundle typedef (alu_op, alu_src, reg_dst, mem_read, mem_write, mem_to_reg, reg_write) so the bubble is a single zero assignment.
- One sub-module: wb_bypass_sel, a combinational per-operand compare-and-select, instantiated twice (rs, rt). It is present only under IDEX_WB_BYPASS_EN.

Test Plan:
- Reset: apply reset with all id_* = 1s, then release → all ex_* = 0 and ex_valid=0 for one edge; the next edge captures the inputs.
- Normal load: id_valid=1, id_rt_data=0x0000_00AA, id_sign_ext_const=0xFFFF_FFF0, id_alu_src=1 → next cycle ex_rt_data=0xAA, ex_sign_ext_const=0xFFFF_FFF0, ex_alu_src=1, ex_valid=1.
- Stall: hold stall=1 for 3 cycles while id_* change → ex_* stay frozen. Release → new id_* appear 1 cycle later.
- Flush during stall: flush=1 and stall=1 on the same edge with ex_reg_write=1 → ex_reg_write=0 and ex_valid=0 next cycle.
- Bypass (macro defined): load id_rs=5 with id_rs_data=0x11 and wb_reg_write=1, wb_rd=5, wb_data=0x22 → ex_rs_data=0x22. Repeat with wb_rd=0 → ex_rs_data=0x11.
- Bypass during stall (macro defined): hold with ex_rt=7; WB writes r7=0x33 → ex_rt_data=0x33 after that edge. Without the macro → ex_rt_data unchanged.

Source files
------------

// File: rtl/idex_pkg.sv
// Shared widths, ALU/select encodings and the EX-stage control bundle for the ID/EX register.
package idex_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALUOP_W    = 4;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_XOR = 4'h4,
    ALU_NOR = 4'h5,
    ALU_SLT = 4'h6,
    ALU_SLL = 4'h7,
    ALU_SRL = 4'h8,
    ALU_SRA = 4'h9,
    ALU_LUI = 4'hA
  } alu_op_e;

  typedef enum logic {
    ALU_SRC_RT  = 1'b0,
    ALU_SRC_IMM = 1'b1
  } alu_src_e;

  typedef enum logic {
    REG_DST_RT = 1'b0,
    REG_DST_RD = 1'b1
  } reg_dst_e;

  // Every control bit travels in one word so a bubble is a single '0 assignment.
  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               reg_dst;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_write;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_pipe_reg_wb_bypass_sel.sv
// wb_bypass_sel: combinational compare-and-select of one register operand against the WB write port.
// Register 0 is hardwired and never takes the WB value.
import idex_pkg::*;

module wb_bypass_sel #(
  parameter int DATA_W     = idex_pkg::DATA_W,
  parameter int REG_ADDR_W = idex_pkg::REG_ADDR_W
) (
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic [REG_ADDR_W-1:0] src_idx,
  input  logic [DATA_W-1:0]     src_data,
  output logic [DATA_W-1:0]     sel_data
);

  logic hit;

  assign hit      = wb_reg_write && (wb_rd != '0) && (wb_rd == src_idx);
  assign sel_data = hit ? wb_data : src_data;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: 1-cycle latency, priority reset > flush > stall > load, id_valid=0 loads a bubble.
// Define IDEX_WB_BYPASS_EN to refresh rs/rt data from the WB write port on load and while stalled.
import idex_pkg::*;

module id_ex_pipe_reg #(
  parameter int DATA_W     = idex_pkg::DATA_W,
  parameter int REG_ADDR_W = idex_pkg::REG_ADDR_W,
  // Must match idex_pkg::ALUOP_W, since alu_op lives inside ctrl_t.
  parameter int ALUOP_W    = idex_pkg::ALUOP_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_pc_plus4,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_sign_ext_const,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [ALUOP_W-1:0]    id_alu_op,
  input  logic                  id_alu_src,
  input  logic                  id_reg_dst,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_mem_to_reg,
  input  logic                  id_reg_write,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_pc_plus4,
  output logic [DATA_W-1:0]     ex_rs_data,
  output logic [DATA_W-1:0]     ex_rt_data,
  output logic [DATA_W-1:0]     ex_sign_ext_const,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [ALUOP_W-1:0]    ex_alu_op,
  output logic                  ex_alu_src,
  output logic                  ex_reg_dst,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_reg_write
);

  logic                  valid_q,   valid_d;
  logic [DATA_W-1:0]     pc_q,      pc_d;
  logic [DATA_W-1:0]     rs_data_q, rs_data_d;
  logic [DATA_W-1:0]     rt_data_q, rt_data_d;
  logic [DATA_W-1:0]     imm_q,     imm_d;
  logic [REG_ADDR_W-1:0] rs_q,      rs_d;
  logic [REG_ADDR_W-1:0] rt_q,      rt_d;
  logic [REG_ADDR_W-1:0] rd_q,      rd_d;
  ctrl_t                 ctrl_q,    ctrl_d;
  ctrl_t                 id_ctrl;

  // Operand data source: the held copy while stalled, otherwise the decode stage.
  logic [DATA_W-1:0]     rs_src_data, rt_src_data;
  logic [DATA_W-1:0]     rs_fwd_data, rt_fwd_data;

  assign id_ctrl = '{alu_op:     id_alu_op,
                     alu_src:    id_alu_src,
                     reg_dst:    id_reg_dst,
                     mem_read:   id_mem_read,
                     mem_write:  id_mem_write,
                     mem_to_reg: id_mem_to_reg,
                     reg_write:  id_reg_write};

  assign rs_src_data = stall ? rs_data_q : id_rs_data;
  assign rt_src_data = stall ? rt_data_q : id_rt_data;

`ifdef IDEX_WB_BYPASS_EN
  logic [REG_ADDR_W-1:0] rs_src_idx, rt_src_idx;

  assign rs_src_idx = stall ? rs_q : id_rs;
  assign rt_src_idx = stall ? rt_q : id_rt;

  wb_bypass_sel #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_rs_bypass (
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .src_idx      (rs_src_idx),
    .src_data     (rs_src_data),
    .sel_data     (rs_fwd_data)
  );

  wb_bypass_sel #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_rt_bypass (
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .src_idx      (rt_src_idx),
    .src_data     (rt_src_data),
    .sel_data     (rt_fwd_data)
  );
`else
  logic unused_wb;

  assign unused_wb   = ^{wb_reg_write, wb_rd, wb_data};
  assign rs_fwd_data = rs_src_data;
  assign rt_fwd_data = rt_src_data;
`endif

  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    ctrl_d    = ctrl_q;
    if (flush || (!stall && !id_valid)) begin
      valid_d   = 1'b0;
      pc_d      = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
      ctrl_d    = CTRL_BUBBLE;
    end else if (stall) begin
      rs_data_d = rs_fwd_data;
      rt_data_d = rt_fwd_data;
    end else begin
      valid_d   = 1'b1;
      pc_d      = id_pc_plus4;
      rs_data_d = rs_fwd_data;
      rt_data_d = rt_fwd_data;
      imm_d     = id_sign_ext_const;
      rs_d      = id_rs;
      rt_d      = id_rt;
      rd_d      = id_rd;
      ctrl_d    = id_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      ctrl_q    <= CTRL_BUBBLE;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign ex_valid          = valid_q;
  assign ex_pc_plus4       = pc_q;
  assign ex_rs_data        = rs_data_q;
  assign ex_rt_data        = rt_data_q;
  assign ex_sign_ext_const = imm_q;
  assign ex_rs             = rs_q;
  assign ex_rt             = rt_q;
  assign ex_rd             = rd_q;
  assign ex_alu_op         = ctrl_q.alu_op;
  assign ex_alu_src        = ctrl_q.alu_src;
  assign ex_reg_dst        = ctrl_q.reg_dst;
  assign ex_mem_read       = ctrl_q.mem_read;
  assign ex_mem_write      = ctrl_q.mem_write;
  assign ex_mem_to_reg     = ctrl_q.mem_to_reg;
  assign ex_reg_write      = ctrl_q.reg_write;

endmodule
